// File: rtl/axi_res_tbl_assoc.sv
// -----------------------------------------------------------------------------
// axi_res_tbl_assoc
//
// Associative LR/SC reservation table for the AXI atomics adapter. Holds up to
// N_ENTRIES reservations tagged {AXI ID, address granule}. The LR/SC FSM sets
// an entry on LR, checks and consumes it on SC, and clears every matching
// granule on any observed write.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   clr_req_i / clr_addr_i        clear request (write observed), clr_gnt_o
//   set_req_i / set_addr_i / set_id_i        set request (LR), set_gnt_o
//   check_req_i / check_addr_i / check_id_i  check request (SC), check_gnt_o
//   check_valid_o / check_res_o   registered one-cycle result of a granted check
//   occupancy_o                   registered count of valid entries
//
// Handshake: each *_req_i is a level held by the requester until the matching
// *_gnt_o is seen high in the same cycle; the operation is committed at the
// clock edge that ends that cycle. Exactly one operation is granted per cycle
// with priority clr > set > check; a gnt is never high without its req.
//
// Build option: define AXI_RES_TBL_TIMEOUT_EN to give each entry an age
// counter that retires it after TIMEOUT_CYCLES cycles. Without it, entries
// live until cleared, consumed by a check, or evicted.
// -----------------------------------------------------------------------------
module axi_res_tbl_assoc #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned N_ENTRIES      = 4,
  parameter int unsigned GRAN_LOG2      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]         clr_addr_i,
  output logic                              clr_gnt_o,
  input  logic                              set_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]         set_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]           set_id_i,
  output logic                              set_gnt_o,
  input  logic                              check_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]         check_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]           check_id_i,
  output logic                              check_gnt_o,
  output logic                              check_valid_o,
  output logic                              check_res_o,
  output logic [$clog2(N_ENTRIES+1)-1:0]    occupancy_o
);

  localparam int unsigned GW = AXI_ADDR_WIDTH - GRAN_LOG2;
  localparam int unsigned OW = $clog2(N_ENTRIES + 1);
  localparam int unsigned PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  // Entry storage
  logic [N_ENTRIES-1:0]    valid_q, valid_d;
  logic [AXI_ID_WIDTH-1:0] id_q   [N_ENTRIES];
  logic [AXI_ID_WIDTH-1:0] id_d   [N_ENTRIES];
  logic [GW-1:0]           gran_q [N_ENTRIES];
  logic [GW-1:0]           gran_d [N_ENTRIES];
  logic [PW-1:0]           victim_q, victim_d;
  logic                    check_valid_q, check_valid_d;
  logic                    check_res_q, check_res_d;
  logic [OW-1:0]           occupancy_q, occupancy_d;

`ifdef AXI_RES_TBL_TIMEOUT_EN
  localparam int unsigned AGW = $clog2(TIMEOUT_CYCLES);
  logic [AGW-1:0] age_q [N_ENTRIES];
  logic [AGW-1:0] age_d [N_ENTRIES];
`endif

  // Granules of the three request addresses
  logic [GW-1:0] clr_gran, set_gran, check_gran;
  assign clr_gran   = clr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
  assign set_gran   = set_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
  assign check_gran = check_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];

  // Byte offsets inside a granule never take part in matching.
  if (GRAN_LOG2 > 0) begin : g_unused_offs
    logic unused_offs;
    assign unused_offs = ^{clr_addr_i[GRAN_LOG2-1:0], set_addr_i[GRAN_LOG2-1:0],
                           check_addr_i[GRAN_LOG2-1:0]};
  end
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);

  // Fixed-priority arbitration
  assign clr_gnt_o   = clr_req_i;
  assign set_gnt_o   = set_req_i & ~clr_req_i;
  assign check_gnt_o = check_req_i & ~clr_req_i & ~set_req_i;

  // Set target: existing entry of the same ID, else lowest free, else victim.
  logic          set_id_hit;
  logic [PW-1:0] set_id_idx;
  logic          free_found;
  logic [PW-1:0] free_idx;
  logic [PW-1:0] set_idx;
  logic          set_evict;

  always_comb begin
    set_id_hit = 1'b0;
    set_id_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && (id_q[i] == set_id_i)) begin
        set_id_hit = 1'b1;
        set_id_idx = PW'(i);
      end
    end
    // Descending scan so the lowest free index is the one left standing.
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PW'(i);
      end
    end
    set_evict = 1'b0;
    if (set_id_hit) begin
      set_idx = set_id_idx;
    end else if (free_found) begin
      set_idx = free_idx;
    end else begin
      set_idx   = victim_q;
      set_evict = 1'b1;
    end
  end

  // Check hit on registered table state
  logic check_hit;
  always_comb begin
    check_hit = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && (id_q[i] == check_id_i) && (gran_q[i] == check_gran)) begin
        check_hit = 1'b1;
      end
    end
  end

  // Table next state
  always_comb begin
    valid_d       = valid_q;
    id_d          = id_q;
    gran_d        = gran_q;
    victim_d      = victim_q;
    check_valid_d = 1'b0;
    check_res_d   = 1'b0;

`ifdef AXI_RES_TBL_TIMEOUT_EN
    // Age every live entry; retire it the edge after it reaches the limit.
    // Applied before the operation so a same-cycle set to that ID revives it.
    for (int i = 0; i < N_ENTRIES; i++) begin
      age_d[i] = '0;
      if (valid_q[i]) begin
        if (age_q[i] == AGW'(TIMEOUT_CYCLES - 1)) begin
          valid_d[i] = 1'b0;
        end else begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
`endif

    if (clr_gnt_o) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (valid_q[i] && (gran_q[i] == clr_gran)) begin
          valid_d[i] = 1'b0;
        end
      end
    end else if (set_gnt_o) begin
      valid_d[set_idx] = 1'b1;
      id_d[set_idx]    = set_id_i;
      gran_d[set_idx]  = set_gran;
`ifdef AXI_RES_TBL_TIMEOUT_EN
      age_d[set_idx]   = '0;
`endif
      if (set_evict) begin
        victim_d = (victim_q == PW'(N_ENTRIES - 1)) ? '0 : victim_q + 1'b1;
      end
    end else if (check_gnt_o) begin
      check_valid_d = 1'b1;
      check_res_d   = check_hit;
      // SC consumes the ID's reservation whether or not the granule matched.
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (valid_q[i] && (id_q[i] == check_id_i)) begin
          valid_d[i] = 1'b0;
        end
      end
    end

    occupancy_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      occupancy_d = occupancy_d + OW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= '0;
      victim_q      <= '0;
      check_valid_q <= 1'b0;
      check_res_q   <= 1'b0;
      occupancy_q   <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        id_q[i]   <= '0;
        gran_q[i] <= '0;
`ifdef AXI_RES_TBL_TIMEOUT_EN
        age_q[i]  <= '0;
`endif
      end
    end else begin
      valid_q       <= valid_d;
      victim_q      <= victim_d;
      check_valid_q <= check_valid_d;
      check_res_q   <= check_res_d;
      occupancy_q   <= occupancy_d;
      for (int i = 0; i < N_ENTRIES; i++) begin
        id_q[i]   <= id_d[i];
        gran_q[i] <= gran_d[i];
`ifdef AXI_RES_TBL_TIMEOUT_EN
        age_q[i]  <= age_d[i];
`endif
      end
    end
  end

  assign check_valid_o = check_valid_q;
  assign check_res_o   = check_res_q;
  assign occupancy_o   = occupancy_q;

endmodule

// File: tb/tb_axi_res_tbl_assoc.sv
// -----------------------------------------------------------------------------
// tb_axi_res_tbl_assoc
//
// Directed bench for axi_res_tbl_assoc (N_ENTRIES=4, GRAN_LOG2=3,
// TIMEOUT_CYCLES=16). Expected SC results are queued when a check is granted
// and compared when check_valid_o pulses. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1-2 units after it.
// -----------------------------------------------------------------------------
module tb_axi_res_tbl_assoc;

  localparam int unsigned AW  = 64;
  localparam int unsigned IW  = 4;
  localparam int unsigned NE  = 4;
  localparam int unsigned GL  = 3;
  localparam int unsigned TMO = 16;
  localparam int unsigned OW  = $clog2(NE + 1);

  // Clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          clr_req_i    = 1'b0;
  logic [AW-1:0] clr_addr_i   = '0;
  logic          clr_gnt_o;
  logic          set_req_i    = 1'b0;
  logic [AW-1:0] set_addr_i   = '0;
  logic [IW-1:0] set_id_i     = '0;
  logic          set_gnt_o;
  logic          check_req_i  = 1'b0;
  logic [AW-1:0] check_addr_i = '0;
  logic [IW-1:0] check_id_i   = '0;
  logic          check_gnt_o;
  logic          check_valid_o;
  logic          check_res_o;
  logic [OW-1:0] occupancy_o;

  axi_res_tbl_assoc #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .N_ENTRIES      (NE),
    .GRAN_LOG2      (GL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_req_i     (clr_req_i),
    .clr_addr_i    (clr_addr_i),
    .clr_gnt_o     (clr_gnt_o),
    .set_req_i     (set_req_i),
    .set_addr_i    (set_addr_i),
    .set_id_i      (set_id_i),
    .set_gnt_o     (set_gnt_o),
    .check_req_i   (check_req_i),
    .check_addr_i  (check_addr_i),
    .check_id_i    (check_id_i),
    .check_gnt_o   (check_gnt_o),
    .check_valid_o (check_valid_o),
    .check_res_o   (check_res_o),
    .occupancy_o   (occupancy_o)
  );

  // Scoreboard
  int          n_total = 0;
  int          n_bad   = 0;
  logic [0:0]  exp_q[$];
  logic        mon_en  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pops one expectation per check_valid_o pulse.
  always begin
    logic [0:0] e;
    @(posedge clk_i);
    #1;
    if (mon_en) begin
      if (check_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_check_valid", check_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("check_res", check_res_o, e);
        end
      end else begin
        chk("check_res_idle_zero", check_res_o, 1'b0);
      end
    end
  end

  // Driver tasks: entered and left 1 unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_set(input logic [AW-1:0] a, input logic [IW-1:0] id);
    set_req_i  = 1'b1;
    set_addr_i = a;
    set_id_i   = id;
    #1;
    chk("set_gnt", set_gnt_o, 1'b1);
    @(posedge clk_i);
    #1;
    set_req_i = 1'b0;
  endtask

  task automatic do_clr(input logic [AW-1:0] a);
    clr_req_i  = 1'b1;
    clr_addr_i = a;
    #1;
    chk("clr_gnt", clr_gnt_o, 1'b1);
    @(posedge clk_i);
    #1;
    clr_req_i = 1'b0;
  endtask

  task automatic do_check(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic e);
    check_req_i  = 1'b1;
    check_addr_i = a;
    check_id_i   = id;
    #1;
    chk("check_gnt", check_gnt_o, 1'b1);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_req_i = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_check_valid", check_valid_o, 1'b0);
    chk("rst_check_res",   check_res_o,   1'b0);
    chk("rst_occupancy",   occupancy_o,   0);
    chk("rst_gnts_idle",   {clr_gnt_o, set_gnt_o, check_gnt_o}, 3'b000);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // 1: set then check in the same granule, second check misses
    do_set(64'h1000, 4'd3);
    chk("occ_after_set", occupancy_o, 1);
    do_check(64'h1004, 4'd3, 1'b1);
    do_check(64'h1004, 4'd3, 1'b0);
    chk("occ_after_consume", occupancy_o, 0);

    // 2: clear inside the granule kills it, clear in the next granule does not
    do_set(64'h2000, 4'd1);
    do_clr(64'h2007);
    do_check(64'h2000, 4'd1, 1'b0);
    do_set(64'h2000, 4'd1);
    do_clr(64'h2008);
    do_check(64'h2000, 4'd1, 1'b1);

    // 3: fill, evict entry 0 then entry 1, overwrite an existing ID
    for (int k = 0; k < 4; k++) begin
      do_set(64'h3000 + 64'(k) * 64'h100, IW'(k));
    end
    chk("occ_full", occupancy_o, 4);
    do_set(64'h3500, 4'd5);
    do_set(64'h3600, 4'd6);
    chk("occ_full_after_evict", occupancy_o, 4);
    do_check(64'h3000, 4'd0, 1'b0);
    do_check(64'h3100, 4'd1, 1'b0);
    do_check(64'h3500, 4'd5, 1'b1);
    do_check(64'h3600, 4'd6, 1'b1);
    do_check(64'h3200, 4'd2, 1'b1);
    chk("occ_one_left", occupancy_o, 1);
    do_set(64'h3800, 4'd3);
    chk("occ_same_id_set", occupancy_o, 1);
    do_check(64'h3300, 4'd3, 1'b0);
    chk("occ_empty_t3", occupancy_o, 0);

    // 4: all three requests together, clr > set > check
    do_set(64'h4000, 4'd4);
    clr_req_i    = 1'b1;  clr_addr_i   = 64'h9000;
    set_req_i    = 1'b1;  set_addr_i   = 64'h7000;  set_id_i   = 4'd7;
    check_req_i  = 1'b1;  check_addr_i = 64'h4000;  check_id_i = 4'd4;
    #1;
    chk("arb_c1_gnts", {clr_gnt_o, set_gnt_o, check_gnt_o}, 3'b100);
    @(posedge clk_i);
    #1;
    clr_req_i = 1'b0;
    #1;
    chk("arb_c2_gnts", {clr_gnt_o, set_gnt_o, check_gnt_o}, 3'b010);
    @(posedge clk_i);
    #1;
    set_req_i = 1'b0;
    #1;
    chk("arb_c3_gnts", {clr_gnt_o, set_gnt_o, check_gnt_o}, 3'b001);
    exp_q.push_back(1'b1);
    @(posedge clk_i);
    #1;
    check_req_i = 1'b0;
    do_check(64'h7000, 4'd7, 1'b1);

`ifdef AXI_RES_TBL_TIMEOUT_EN
    // 5: check at age 15 hits; an untouched entry expires after 16 cycles
    do_set(64'h40, 4'd2);
    idle(15);
    do_check(64'h40, 4'd2, 1'b1);
    do_set(64'h40, 4'd2);
    idle(15);
    chk("occ_age15", occupancy_o, 1);
    idle(1);
    chk("occ_expired", occupancy_o, 0);
    do_check(64'h40, 4'd2, 1'b0);
`endif

    // 6: reset while a check result is showing
    do_set(64'h1100, 4'd1);
    do_set(64'h1200, 4'd2);
    check_req_i  = 1'b1;
    check_addr_i = 64'h1100;
    check_id_i   = 4'd1;
    #1;
    chk("check_gnt_pre_rst", check_gnt_o, 1'b1);
    exp_q.push_back(1'b1);
    @(posedge clk_i);
    #1;
    check_req_i = 1'b0;
    #1;
    chk("occ_pre_rst", occupancy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_check_valid", check_valid_o, 1'b0);
    chk("rst_async_check_res",   check_res_o,   1'b0);
    chk("rst_async_occupancy",   occupancy_o,   0);
    idle(1);
    rst_ni = 1'b1;
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
